univ_shift_reg: RTL and testbench

Parametrised universal shift register, successor to the team's fixed 4-bit right-shift register. Adds left shift, rotate, arithmetic shift, parallel load, synchronous clear and a counted burst-shift sequencer with a busy/done handshake. Used as a serial/parallel converter and as a multi-position shifter in datapath and test designs.

---
 rtl/univ_shift_reg.sv | 123 ++++++++++++
 tb/tb_univ_shift_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: single-cycle hold/shift/rotate/load/clear
// plus a counted burst-shift sequencer with a busy/done handshake.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sdr,
  input  logic             sdl,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNTW-1:0]  count,
  output logic [WIDTH-1:0] q,
  output logic             sor,
  output logic             sol,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_ROR   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_LOAD  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_n;
  logic [CNTW-1:0]  rem, rem_n;
  logic [2:0]       bmode, bmode_n;

  // Next value of the register for one application of an operation.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (op)
      M_HOLD: r = cur;
      M_SHR:  r = {sr, cur[WIDTH-1:1]};
      M_SHL:  r = {cur[WIDTH-2:0], sl};
      M_ROR:  r = {cur[0], cur[WIDTH-1:1]};
      M_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      M_LOAD: r = ld;
      M_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLR:  r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic logic is_shift_class(input logic [2:0] op);
    return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) ||
           (op == M_ROL) || (op == M_ASR);
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state <= IDLE;
      q     <= '0;
      rem   <= '0;
      bmode <= M_HOLD;
    end else begin
      state <= state_n;
      q     <= q_n;
      rem   <= rem_n;
      bmode <= bmode_n;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    q_n     = q;
    rem_n   = rem;
    bmode_n = bmode;
    case (state)
      IDLE: begin
        if (start && is_shift_class(mode)) begin
          bmode_n = mode;
          rem_n   = count;
          state_n = (count != '0) ? SHIFT : DONE;
        end else if (en) begin
          q_n = apply_op(mode, q, sdr, sdl, d);
        end
      end
      SHIFT: begin
        q_n   = apply_op(bmode, q, sdr, sdl, d);
        rem_n = rem - CNTW'(1);
        if (rem == CNTW'(1)) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status decodes straight from the state register; serial outs track q.
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign sor  = q[0];
  assign sol  = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed testbench for univ_shift_reg (WIDTH=4, CNTW=4) with an expectation queue.
module tb_univ_shift_reg;

  logic       clk;
  logic       clrb;
  logic       en;
  logic [2:0] mode;
  logic       sdr;
  logic       sdl;
  logic [3:0] d;
  logic       start;
  logic [3:0] count;
  logic [3:0] q;
  logic       sor;
  logic       sol;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  univ_shift_reg #(.WIDTH(4), .CNTW(4)) dut (
    .clk   (clk),
    .clrb  (clrb),
    .en    (en),
    .mode  (mode),
    .sdr   (sdr),
    .sdl   (sdl),
    .d     (d),
    .start (start),
    .count (count),
    .q     (q),
    .sor   (sor),
    .sol   (sol),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_push(input string tag, input logic [3:0] eq,
                             input logic eb, input logic ed);
    exp_t e;
    e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare against live outputs.
  task automatic check_pop();
    exp_t       e;
    logic [7:0] obs;
    logic [7:0] exv;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: size=%0d expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {q, busy, done, sor, sol};
      exv = {e.q, e.busy, e.done, e.q[0], e.q[3]};
      assert (obs === exv) else begin
        errors++;
        $error("FAIL %s: q/busy/done/sor/sol=%b_%b%b%b%b expected %b_%b%b%b%b",
               e.tag, obs[7:4], obs[3], obs[2], obs[1], obs[0],
               exv[7:4], exv[3], exv[2], exv[1], exv[0]);
      end
    end
  endtask

  // Drive inputs on the falling edge, expect the result after the next rising edge.
  task automatic step(input string tag, input logic en_v, input logic [2:0] mode_v,
                      input logic sdr_v, input logic sdl_v, input logic [3:0] d_v,
                      input logic start_v, input logic [3:0] cnt_v,
                      input logic [3:0] eq, input logic eb, input logic ed);
    @(negedge clk);
    en = en_v; mode = mode_v; sdr = sdr_v; sdl = sdl_v;
    d = d_v; start = start_v; count = cnt_v;
    expect_push(tag, eq, eb, ed);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    clrb = 1'b0; en = 1'b0; mode = 3'b000; sdr = 1'b0; sdl = 1'b0;
    d = 4'h0; start = 1'b0; count = 4'h0;
    #1;
    expect_push("reset_state", 4'b0000, 1'b0, 1'b0);
    check_pop();
    @(negedge clk);
    @(negedge clk);
    clrb = 1'b1;

    // Right-shift regression
    step("idle_after_reset", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b0000, 0, 0);
    step("shr_1", 1, 3'b001, 1, 0, 4'h0, 0, 4'h0, 4'b1000, 0, 0);
    step("shr_2", 1, 3'b001, 1, 0, 4'h0, 0, 4'h0, 4'b1100, 0, 0);
    step("shr_3", 1, 3'b001, 1, 0, 4'h0, 0, 4'h0, 4'b1110, 0, 0);
    step("shr_4", 1, 3'b001, 0, 0, 4'h0, 0, 4'h0, 4'b0111, 0, 0);
    step("shr_5", 1, 3'b001, 0, 0, 4'h0, 0, 4'h0, 4'b0011, 0, 0);

    // Load and rotate
    step("load_1001", 1, 3'b101, 0, 0, 4'b1001, 0, 4'h0, 4'b1001, 0, 0);
    step("rol_1", 1, 3'b100, 0, 0, 4'h0, 0, 4'h0, 4'b0011, 0, 0);
    step("rol_2", 1, 3'b100, 0, 0, 4'h0, 0, 4'h0, 4'b0110, 0, 0);
    step("ror_1", 1, 3'b011, 0, 0, 4'h0, 0, 4'h0, 4'b0011, 0, 0);
    step("shl_sdl1", 1, 3'b010, 0, 1, 4'h0, 0, 4'h0, 4'b0111, 0, 0);

    // Arithmetic shift, clear, hold, en gating
    step("load_1010", 1, 3'b101, 0, 0, 4'b1010, 0, 4'h0, 4'b1010, 0, 0);
    step("asr_1", 1, 3'b110, 0, 0, 4'h0, 0, 4'h0, 4'b1101, 0, 0);
    step("asr_2", 1, 3'b110, 0, 0, 4'h0, 0, 4'h0, 4'b1110, 0, 0);
    step("sync_clear", 1, 3'b111, 0, 0, 4'h0, 0, 4'h0, 4'b0000, 0, 0);
    step("hold_zero", 1, 3'b000, 1, 1, 4'hF, 0, 4'h0, 4'b0000, 0, 0);
    step("load_0110", 1, 3'b101, 0, 0, 4'b0110, 0, 4'h0, 4'b0110, 0, 0);
    step("hold_0110", 1, 3'b000, 1, 1, 4'hF, 0, 4'h0, 4'b0110, 0, 0);
    step("en_low_gates", 0, 3'b101, 1, 1, 4'hF, 0, 4'h0, 4'b0110, 0, 0);

    // Left burst of 3; junk on mode/en/d/start while busy
    step("load_0001", 1, 3'b101, 0, 0, 4'b0001, 0, 4'h0, 4'b0001, 0, 0);
    step("burst_accept", 1, 3'b010, 0, 0, 4'h0, 1, 4'd3, 4'b0001, 1, 0);
    step("burst_e1", 1, 3'b101, 0, 0, 4'hF, 1, 4'd5, 4'b0010, 1, 0);
    step("burst_e2", 1, 3'b111, 0, 0, 4'hF, 0, 4'd7, 4'b0100, 1, 0);
    step("burst_e3_done", 1, 3'b101, 0, 0, 4'hA, 1, 4'd2, 4'b1000, 1, 1);
    step("done_ignores_start", 0, 3'b001, 1, 0, 4'h0, 1, 4'd2, 4'b1000, 0, 0);
    step("after_burst_idle", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b1000, 0, 0);

    // Right burst of 2 with live sdr
    step("rburst_accept", 0, 3'b001, 1, 0, 4'h0, 1, 4'd2, 4'b1000, 1, 0);
    step("rburst_e1", 0, 3'b000, 1, 0, 4'h0, 0, 4'h0, 4'b1100, 1, 0);
    step("rburst_e2_done", 0, 3'b000, 1, 0, 4'h0, 0, 4'h0, 4'b1110, 1, 1);
    step("rburst_idle", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b1110, 0, 0);

    // Zero-count burst and ignored start
    step("zero_count_done", 1, 3'b011, 0, 0, 4'h0, 1, 4'd0, 4'b1110, 1, 1);
    step("zero_count_idle", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b1110, 0, 0);
    step("start_load_ignored", 0, 3'b101, 0, 0, 4'h0, 1, 4'd3, 4'b1110, 0, 0);
    step("start_ignored_idle", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b1110, 0, 0);

    // Reset mid-burst, between clock edges
    step("long_accept", 0, 3'b011, 0, 0, 4'h0, 1, 4'd8, 4'b1110, 1, 0);
    step("long_e1", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b0111, 1, 0);
    step("long_e2", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b1011, 1, 0);
    step("long_e3", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b1101, 1, 0);
    #2;
    clrb = 1'b0;
    #1;
    expect_push("async_reset_mid_burst", 4'b0000, 1'b0, 1'b0);
    check_pop();
    step("reset_held", 1, 3'b101, 0, 0, 4'hF, 0, 4'h0, 4'b0000, 0, 0);
    @(negedge clk);
    clrb = 1'b1;

    // New burst after reset release
    step("load_0011", 1, 3'b101, 0, 0, 4'b0011, 0, 4'h0, 4'b0011, 0, 0);
    step("post_accept", 0, 3'b100, 0, 0, 4'h0, 1, 4'd1, 4'b0011, 1, 0);
    step("post_e1_done", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b0110, 1, 1);
    step("post_idle", 0, 3'b000, 0, 0, 4'h0, 0, 4'h0, 4'b0110, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: size=%0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
